// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller:
// opcodes, funct fields, ALU codes, FSM states, instr classes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_DW  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_ADDI,
    C_LD,
    C_SD,
    C_BEQ,
    C_BAD
  } iclass_t;

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Fetch-side valid/ready instruction handshake.
// master = fetch, slave = controller.
interface riscv_multicycle_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;

  modport master (
    output instr_valid,
    output instruction,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instruction,
    output instr_ready
  );
endinterface

// File: rtl/riscv_multicycle_ctrl_alu_op_decode.sv
// Combinational opcode/funct3/funct7 -> ALUop, class, legal.
// Ports: opcode, funct3, funct7 in; aluop, cls, legal out.
module alu_op_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] aluop,
  output iclass_t    cls,
  output logic       legal
);

  logic is_r;
  assign is_r = (opcode == OP_R);

  always_comb begin
    aluop = ALU_ADD;
    cls   = C_BAD;
    unique case (1'b1)
      is_r && funct3 == F3_ADD && funct7 == F7_ADD: begin
        aluop = ALU_ADD;
        cls   = C_R;
      end
      is_r && funct3 == F3_ADD && funct7 == F7_SUB: begin
        aluop = ALU_SUB;
        cls   = C_R;
      end
      is_r && funct3 == F3_AND && funct7 == F7_ADD: begin
        aluop = ALU_AND;
        cls   = C_R;
      end
      is_r && funct3 == F3_OR && funct7 == F7_ADD: begin
        aluop = ALU_OR;
        cls   = C_R;
      end
      opcode == OP_ADDI && funct3 == F3_ADD: begin
        cls = C_ADDI;
      end
      opcode == OP_LD && funct3 == F3_DW: begin
        cls = C_LD;
      end
      opcode == OP_SD && funct3 == F3_DW: begin
        cls = C_SD;
      end
      opcode == OP_BEQ && funct3 == F3_BEQ: begin
        aluop = ALU_SUB;
        cls   = C_BEQ;
      end
      default: begin
        aluop = ALU_ADD;
        cls   = C_BAD;
      end
    endcase
  end

  assign legal = (cls != C_BAD);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control sequencer DECODE->EXEC->MEM->WB.
// Ports: clk, rst_n, fetch (slave if), zero; registered datapath controls.
module riscv_multicycle_ctrl #(
  parameter int MEM_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  riscv_multicycle_ctrl_if.slave fetch,
  input  logic       zero,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic [3:0] ALUop,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic       branch_taken,
  output logic       illegal,
  output logic       done
);
  import riscv_ctrl_pkg::*;

  localparam logic [3:0] CNT_INIT = 4'(MEM_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ready_q;
  logic       accept;

  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic [6:0] f7_q;
  logic [4:0] rd_q;

  logic [3:0] dec_aluop;
  iclass_t    dec_cls;
  logic       dec_legal;

  logic       rw_d, as_d, mw_d, mr_d;
  logic       mt_d, bt_d, il_d, dn_d;
  logic [3:0] op_d;

  alu_op_decode u_dec (
    .opcode (op_q),
    .funct3 (f3_q),
    .funct7 (f7_q),
    .aluop  (dec_aluop),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  assign fetch.instr_ready = ready_q;
  assign accept = (state_q == S_IDLE)
                && fetch.instr_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = 1'b0;
    as_d    = 1'b0;
    op_d    = 4'b0000;
    mw_d    = 1'b0;
    mr_d    = 1'b0;
    mt_d    = 1'b0;
    bt_d    = 1'b0;
    il_d    = 1'b0;
    dn_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!dec_legal) begin
          il_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // ALU inputs stay valid from here until retire
        as_d = (dec_cls != C_R) && (dec_cls != C_BEQ);
        op_d = dec_aluop;
        unique case (dec_cls)
          C_BEQ: begin
            bt_d    = zero;
            dn_d    = 1'b1;
            state_d = S_IDLE;
          end
          C_LD, C_SD: begin
            cnt_d   = CNT_INIT;
            state_d = S_MEM;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        as_d = 1'b1;
        op_d = dec_aluop;
        mr_d = (dec_cls == C_LD);
        mw_d = (dec_cls == C_SD);
        if (cnt_q == 4'd0) begin
          if (dec_cls == C_SD) begin
            dn_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        as_d    = (dec_cls != C_R);
        op_d    = dec_aluop;
        rw_d    = (rd_q != 5'd0);
        mt_d    = (dec_cls == C_LD);
        dn_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b0;
      op_q         <= 7'd0;
      f3_q         <= 3'd0;
      f7_q         <= 7'd0;
      rd_q         <= 5'd0;
      RegWrite     <= 1'b0;
      ALUSrc       <= 1'b0;
      ALUop        <= 4'd0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
      MemtoReg     <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= (state_d == S_IDLE);
      if (accept) begin
        op_q <= fetch.instruction[6:0];
        rd_q <= fetch.instruction[11:7];
        f3_q <= fetch.instruction[14:12];
        f7_q <= fetch.instruction[31:25];
      end
      RegWrite     <= rw_d;
      ALUSrc       <= as_d;
      ALUop        <= op_d;
      MemWrite     <= mw_d;
      MemRead      <= mr_d;
      MemtoReg     <= mt_d;
      branch_taken <= bt_d;
      illegal      <= il_d;
      done         <= dn_d;
    end
  end

endmodule
